// File: rtl/ae_cfg_pkg.sv
// Shared types and constants for the AE-to-sensor exposure writer.
package ae_cfg_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      IDLE,
      CALC,
      WRITE,
      GAP,
      DONE,
      ERR
   } ae_state_t;

   // Default sensor addressing
   localparam logic [7:0]  DEF_DEV_ADDR  = 8'h34;
   localparam logic [15:0] DEF_REG_HOLD  = 16'h0104;
   localparam logic [15:0] DEF_REG_EXP_H = 16'h015A;
   localparam logic [15:0] DEF_REG_EXP_L = 16'h015B;

   // Default exposure scaling and write watchdog
   localparam logic [15:0] DEF_STEP      = 16'd8;
   localparam logic [15:0] DEF_MAX_LINES = 16'd1760;
   localparam logic [31:0] DEF_TIMEOUT   = 32'd2_400_000;

   // Group-hold data bytes that bracket the exposure update
   localparam logic [7:0]  HOLD_ON  = 8'h01;
   localparam logic [7:0]  HOLD_OFF = 8'h00;

   // Number of register writes in one update and the last write index
   localparam int          SEQ_LEN  = 4;
   localparam logic [1:0]  LAST_IDX = 2'(SEQ_LEN - 1);

   // AE level assumed until the first request arrives
   localparam logic [7:0]  RESET_AE = 8'd50;

endpackage

// File: rtl/ae_lines_calc.sv
// Converts an AE level into a clamped coarse-integration line count.
module ae_lines_calc
   import ae_cfg_pkg::*;
#(
   parameter logic [15:0] STEP      = DEF_STEP,
   parameter logic [15:0] MAX_LINES = DEF_MAX_LINES
) (
   input  logic [7:0]  ae,
   output logic [15:0] lines
);

   logic [23:0] product;

   assign product = {16'd0, ae} * {8'd0, STEP};

   // Clamp large products to the sensor limit; zero passes through unchanged
   always_comb begin
      lines = product[15:0];
      if (product > {8'd0, MAX_LINES}) begin
         lines = MAX_LINES;
      end
   end

endmodule

// File: rtl/ae_cfg_ctrl.sv
// Accepts AE update requests and writes the resulting exposure line count
// to the sensor through the shared I2C write port, inside a group hold.
module ae_cfg_ctrl
   import ae_cfg_pkg::*;
#(
   parameter logic [7:0]  DEV_ADDR  = DEF_DEV_ADDR,
   parameter logic [15:0] REG_HOLD  = DEF_REG_HOLD,
   parameter logic [15:0] REG_EXP_H = DEF_REG_EXP_H,
   parameter logic [15:0] REG_EXP_L = DEF_REG_EXP_L,
   parameter logic [15:0] STEP      = DEF_STEP,
   parameter logic [15:0] MAX_LINES = DEF_MAX_LINES,
   parameter logic [31:0] TIMEOUT   = DEF_TIMEOUT
) (
   input  logic        I_clk,
   input  logic        I_rst,
   input  logic        I_cam_cfg_done,
   input  logic        I_ae_req,
   input  logic [7:0]  I_ae,
   output logic        O_ae_cfg_done,
   output logic        O_ae_err,
   output logic        O_busy,
   output logic        O_wr_req,
   output logic [7:0]  O_dev_addr,
   output logic [15:0] O_reg_addr,
   output logic [7:0]  O_wr_data,
   input  logic        I_wr_done
);

   ae_state_t   state;
   logic        pend_flag;
   logic [7:0]  pend_ae;
   logic [7:0]  cur_ae;
   logic [15:0] calc_lines;
   logic [15:0] lines_q;
   logic [1:0]  idx;
   logic [31:0] wd_cnt;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_data;

   ae_lines_calc #(
      .STEP      (STEP),
      .MAX_LINES (MAX_LINES)
   ) u_lines_calc (
      .ae    (cur_ae),
      .lines (calc_lines)
   );

   // Register/data pair for the write selected by the current index
   always_comb begin
      cmd_addr = REG_HOLD;
      cmd_data = HOLD_OFF;
      case (idx)
         2'd0: begin
            cmd_addr = REG_HOLD;
            cmd_data = HOLD_ON;
         end
         2'd1: begin
            cmd_addr = REG_EXP_H;
            cmd_data = lines_q[15:8];
         end
         2'd2: begin
            cmd_addr = REG_EXP_L;
            cmd_data = lines_q[7:0];
         end
         default: begin
            cmd_addr = REG_HOLD;
            cmd_data = HOLD_OFF;
         end
      endcase
   end

   // Sequencer, request capture, write watchdog and registered outputs
   always_ff @(posedge I_clk) begin
      if (I_rst) begin
         state         <= IDLE;
         pend_flag     <= 1'b0;
         pend_ae       <= RESET_AE;
         cur_ae        <= 8'd0;
         lines_q       <= 16'd0;
         idx           <= 2'd0;
         wd_cnt        <= 32'd0;
         O_wr_req      <= 1'b0;
         O_reg_addr    <= 16'd0;
         O_wr_data     <= 8'd0;
         O_ae_cfg_done <= 1'b0;
         O_ae_err      <= 1'b0;
         O_dev_addr    <= DEV_ADDR;
      end else begin
         O_dev_addr    <= DEV_ADDR;
         O_ae_cfg_done <= 1'b0;
         O_ae_err      <= 1'b0;

         case (state)
            IDLE: begin
               if (pend_flag && I_cam_cfg_done) begin
                  cur_ae    <= pend_ae;
                  pend_flag <= 1'b0;
                  state     <= CALC;
               end
            end

            CALC: begin
               lines_q    <= calc_lines;
               idx        <= 2'd0;
               wd_cnt     <= 32'd0;
               O_wr_req   <= 1'b1;
               O_reg_addr <= REG_HOLD;
               O_wr_data  <= HOLD_ON;
               state      <= WRITE;
            end

            WRITE: begin
               if (I_wr_done) begin
                  O_wr_req <= 1'b0;
                  wd_cnt   <= 32'd0;
                  if (idx == LAST_IDX) begin
                     O_ae_cfg_done <= 1'b1;
                     state         <= DONE;
                  end else begin
                     idx   <= idx + 2'd1;
                     state <= GAP;
                  end
               end else if (wd_cnt == TIMEOUT - 32'd1) begin
                  O_wr_req <= 1'b0;
                  wd_cnt   <= 32'd0;
                  O_ae_err <= 1'b1;
                  state    <= ERR;
               end else begin
                  wd_cnt <= wd_cnt + 32'd1;
               end
            end

            GAP: begin
               O_wr_req   <= 1'b1;
               O_reg_addr <= cmd_addr;
               O_wr_data  <= cmd_data;
               state      <= WRITE;
            end

            DONE: begin
               state <= IDLE;
            end

            ERR: begin
               O_wr_req <= 1'b0;
               state    <= IDLE;
            end

            default: begin
               O_wr_req <= 1'b0;
               state    <= IDLE;
            end
         endcase

         // A new request always wins, even over the one being consumed
         if (I_ae_req) begin
            pend_ae   <= I_ae;
            pend_flag <= 1'b1;
         end
      end
   end

   assign O_busy = (state != IDLE);

endmodule

// File: tb/tb_ae_cfg_ctrl.sv
// Directed bench for ae_cfg_ctrl with a hand-driven I2C acknowledge.
module tb_ae_cfg_ctrl;

   logic        I_clk;
   logic        I_rst;
   logic        I_cam_cfg_done;
   logic        I_ae_req;
   logic [7:0]  I_ae;
   logic        O_ae_cfg_done;
   logic        O_ae_err;
   logic        O_busy;
   logic        O_wr_req;
   logic [7:0]  O_dev_addr;
   logic [15:0] O_reg_addr;
   logic [7:0]  O_wr_data;
   logic        I_wr_done;

   int checkCount = 0;
   int errorCount = 0;
   int doneCount  = 0;
   int errCount   = 0;

   ae_cfg_ctrl #(
      .TIMEOUT (32'd100)
   ) dut (
      .I_clk          (I_clk),
      .I_rst          (I_rst),
      .I_cam_cfg_done (I_cam_cfg_done),
      .I_ae_req       (I_ae_req),
      .I_ae           (I_ae),
      .O_ae_cfg_done  (O_ae_cfg_done),
      .O_ae_err       (O_ae_err),
      .O_busy         (O_busy),
      .O_wr_req       (O_wr_req),
      .O_dev_addr     (O_dev_addr),
      .O_reg_addr     (O_reg_addr),
      .O_wr_data      (O_wr_data),
      .I_wr_done      (I_wr_done)
   );

   // 10-unit clock period
   initial I_clk = 1'b0;
   always #5 I_clk = ~I_clk;

   // Count done and error pulses, one per high cycle
   always @(negedge I_clk) begin
      if (O_ae_cfg_done) doneCount++;
      if (O_ae_err) errCount++;
   end

   // Hard stop in case something hangs
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish, required finish before limit");
      $fatal(1, "[TB] global timeout");
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One-cycle AE request, driven at a negedge
   task automatic applyStimulus(input logic [7:0] ae);
      I_ae_req = 1'b1;
      I_ae     = ae;
      @(negedge I_clk);
      I_ae_req = 1'b0;
   endtask

   // Wait for a write, check it, hold 10 cycles, acknowledge, check the drop
   task automatic serviceWrite(input string tag, input logic [15:0] addr,
                               input logic [7:0] data, input int expWait);
      int n;
      n = 0;
      while (!O_wr_req && n < 30) begin
         @(negedge I_clk);
         n++;
      end
      checkOutput({tag, "_req"}, {31'd0, O_wr_req}, 32'd1);
      if (expWait >= 0) checkOutput({tag, "_wait"}, n, expWait);
      checkOutput({tag, "_addr"}, {16'd0, O_reg_addr}, {16'd0, addr});
      checkOutput({tag, "_data"}, {24'd0, O_wr_data}, {24'd0, data});
      checkOutput({tag, "_dev"}, {24'd0, O_dev_addr}, 32'h34);
      repeat (10) @(negedge I_clk);
      checkOutput({tag, "_hold_req"}, {31'd0, O_wr_req}, 32'd1);
      checkOutput({tag, "_hold_addr"}, {16'd0, O_reg_addr}, {16'd0, addr});
      checkOutput({tag, "_hold_data"}, {24'd0, O_wr_data}, {24'd0, data});
      I_wr_done = 1'b1;
      @(negedge I_clk);
      I_wr_done = 1'b0;
      checkOutput({tag, "_drop"}, {31'd0, O_wr_req}, 32'd0);
   endtask

   // Count write requests seen over a quiet window
   task automatic quietWindow(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge I_clk);
         if (O_wr_req) seen++;
      end
   endtask

   initial begin
      int n;
      int seen;
      int busySeen;
      I_rst          = 1'b1;
      I_cam_cfg_done = 1'b1;
      I_ae_req       = 1'b0;
      I_ae           = 8'd0;
      I_wr_done      = 1'b0;
      repeat (3) @(negedge I_clk);

      // Reset state
      checkOutput("rst_wr_req", {31'd0, O_wr_req}, 32'd0);
      checkOutput("rst_busy", {31'd0, O_busy}, 32'd0);
      checkOutput("rst_done", {31'd0, O_ae_cfg_done}, 32'd0);
      checkOutput("rst_err", {31'd0, O_ae_err}, 32'd0);
      checkOutput("rst_dev", {24'd0, O_dev_addr}, 32'h34);
      checkOutput("rst_addr", {16'd0, O_reg_addr}, 32'h0);
      checkOutput("rst_data", {24'd0, O_wr_data}, 32'h0);
      I_rst = 1'b0;
      @(negedge I_clk);

      // AE 51 -> 408 lines, latency of two cycles to the first write
      applyStimulus(8'd51);
      checkOutput("t1_lat_k", {31'd0, O_wr_req}, 32'd0);
      @(negedge I_clk);
      checkOutput("t1_calc_busy", {31'd0, O_busy}, 32'd1);
      checkOutput("t1_calc_req", {31'd0, O_wr_req}, 32'd0);
      @(negedge I_clk);
      checkOutput("t1_first_req", {31'd0, O_wr_req}, 32'd1);
      serviceWrite("t1_w0", 16'h0104, 8'h01, 0);
      serviceWrite("t1_w1", 16'h015A, 8'h01, 1);
      serviceWrite("t1_w2", 16'h015B, 8'h98, 1);
      serviceWrite("t1_w3", 16'h0104, 8'h00, -1);
      repeat (2) @(negedge I_clk);
      checkOutput("t1_done_count", doneCount, 32'd1);
      checkOutput("t1_idle_busy", {31'd0, O_busy}, 32'd0);

      // Stray acknowledge while idle does nothing
      I_wr_done = 1'b1;
      @(negedge I_clk);
      I_wr_done = 1'b0;
      quietWindow(5, seen);
      checkOutput("stray_ack_req", seen, 32'd0);
      checkOutput("stray_ack_busy", {31'd0, O_busy}, 32'd0);

      // AE 255 clamps 2040 to 1760 = 0x06E0
      applyStimulus(8'd255);
      serviceWrite("t2_w0", 16'h0104, 8'h01, -1);
      serviceWrite("t2_w1", 16'h015A, 8'h06, 1);
      serviceWrite("t2_w2", 16'h015B, 8'hE0, 1);
      serviceWrite("t2_w3", 16'h0104, 8'h00, -1);
      repeat (2) @(negedge I_clk);
      checkOutput("t2_done_count", doneCount, 32'd2);

      // AE 10 runs, AE 20 arrives mid-sequence and runs exactly once more
      applyStimulus(8'd10);
      serviceWrite("t3a_w0", 16'h0104, 8'h01, -1);
      applyStimulus(8'd20);
      serviceWrite("t3a_w1", 16'h015A, 8'h00, 0);
      serviceWrite("t3a_w2", 16'h015B, 8'h50, 1);
      serviceWrite("t3a_w3", 16'h0104, 8'h00, -1);
      serviceWrite("t3b_w0", 16'h0104, 8'h01, -1);
      serviceWrite("t3b_w1", 16'h015A, 8'h00, 1);
      serviceWrite("t3b_w2", 16'h015B, 8'hA0, 1);
      serviceWrite("t3b_w3", 16'h0104, 8'h00, -1);
      quietWindow(20, seen);
      checkOutput("t3_no_third", seen, 32'd0);
      checkOutput("t3_done_count", doneCount, 32'd4);

      // Request held until the camera finishes its initial configuration
      I_cam_cfg_done = 1'b0;
      @(negedge I_clk);
      applyStimulus(8'd100);
      seen = 0;
      busySeen = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge I_clk);
         if (O_wr_req) seen++;
         if (O_busy) busySeen++;
      end
      checkOutput("t4_held_req", seen, 32'd0);
      checkOutput("t4_held_busy", busySeen, 32'd0);
      I_cam_cfg_done = 1'b1;
      @(negedge I_clk);
      checkOutput("t4_rise_1", {31'd0, O_wr_req}, 32'd0);
      @(negedge I_clk);
      checkOutput("t4_rise_2", {31'd0, O_wr_req}, 32'd1);
      serviceWrite("t4_w0", 16'h0104, 8'h01, 0);
      serviceWrite("t4_w1", 16'h015A, 8'h03, 1);
      serviceWrite("t4_w2", 16'h015B, 8'h20, 1);
      serviceWrite("t4_w3", 16'h0104, 8'h00, -1);
      repeat (2) @(negedge I_clk);
      checkOutput("t4_done_count", doneCount, 32'd5);

      // Unacknowledged write times out after 100 cycles
      applyStimulus(8'd5);
      n = 0;
      while (!O_wr_req && n < 30) begin
         @(negedge I_clk);
         n++;
      end
      checkOutput("t5_req", {31'd0, O_wr_req}, 32'd1);
      n = 1;
      while (O_wr_req && n < 200) begin
         @(negedge I_clk);
         if (O_wr_req) n++;
      end
      checkOutput("t5_high_cycles", n, 32'd100);
      checkOutput("t5_err_pulse", {31'd0, O_ae_err}, 32'd1);
      @(negedge I_clk);
      checkOutput("t5_err_count", errCount, 32'd1);
      checkOutput("t5_err_cleared", {31'd0, O_ae_err}, 32'd0);
      checkOutput("t5_idle_busy", {31'd0, O_busy}, 32'd0);
      quietWindow(10, seen);
      checkOutput("t5_no_retry", seen, 32'd0);
      checkOutput("t5_no_done", doneCount, 32'd5);

      // Reset during the third write abandons the sequence
      applyStimulus(8'd51);
      serviceWrite("t6_w0", 16'h0104, 8'h01, -1);
      serviceWrite("t6_w1", 16'h015A, 8'h01, 1);
      n = 0;
      while (!O_wr_req && n < 30) begin
         @(negedge I_clk);
         n++;
      end
      checkOutput("t6_w2_addr", {16'd0, O_reg_addr}, 32'h015B);
      I_rst = 1'b1;
      @(negedge I_clk);
      I_rst = 1'b0;
      checkOutput("t6_rst_req", {31'd0, O_wr_req}, 32'd0);
      checkOutput("t6_rst_busy", {31'd0, O_busy}, 32'd0);
      checkOutput("t6_rst_addr", {16'd0, O_reg_addr}, 32'h0);
      checkOutput("t6_rst_data", {24'd0, O_wr_data}, 32'h0);
      checkOutput("t6_rst_done", {31'd0, O_ae_cfg_done}, 32'd0);
      checkOutput("t6_rst_err", {31'd0, O_ae_err}, 32'd0);
      checkOutput("t6_rst_dev", {24'd0, O_dev_addr}, 32'h34);
      quietWindow(5, seen);
      checkOutput("t6_quiet", seen, 32'd0);
      checkOutput("t6_done_count", doneCount, 32'd5);
      applyStimulus(8'd51);
      serviceWrite("t6r_w0", 16'h0104, 8'h01, -1);
      serviceWrite("t6r_w1", 16'h015A, 8'h01, 1);
      serviceWrite("t6r_w2", 16'h015B, 8'h98, 1);
      serviceWrite("t6r_w3", 16'h0104, 8'h00, -1);
      repeat (2) @(negedge I_clk);
      checkOutput("t6_final_done", doneCount, 32'd6);
      checkOutput("t6_final_err", errCount, 32'd1);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
